// File: rtl/riscv_pkg.sv
// riscv_pkg: shared definitions for the multicycle RV32I control unit.
// Holds the FSM state enum, the opcode constants, the alu_ctrl encodings
// and the datapath mux-select constants.
package riscv_pkg;

    localparam int unsigned STATE_W  = 4;
    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned ALU_W    = 4;
    localparam int unsigned SEL_W    = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_EXEC_I = 4'd4,
        S_ADDR   = 4'd5,
        S_LOAD   = 4'd6,
        S_STORE  = 4'd7,
        S_WB_ALU = 4'd8,
        S_WB_MEM = 4'd9,
        S_BRANCH = 4'd10,
        S_JAL    = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    // Opcodes handled by the control unit
    localparam logic [OPCODE_W-1:0] OP_R      = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_I      = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;

    // ALU operation encodings
    localparam logic [ALU_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALU_W-1:0] ALU_AND  = 4'd2;
    localparam logic [ALU_W-1:0] ALU_OR   = 4'd3;
    localparam logic [ALU_W-1:0] ALU_XOR  = 4'd4;
    localparam logic [ALU_W-1:0] ALU_SLT  = 4'd5;
    localparam logic [ALU_W-1:0] ALU_SLTU = 4'd6;
    localparam logic [ALU_W-1:0] ALU_SLL  = 4'd7;
    localparam logic [ALU_W-1:0] ALU_SRL  = 4'd8;
    localparam logic [ALU_W-1:0] ALU_SRA  = 4'd9;

    // ALU operand A select
    localparam logic [SEL_W-1:0] SRC_A_PC     = 2'd0;
    localparam logic [SEL_W-1:0] SRC_A_PC_OLD = 2'd1;
    localparam logic [SEL_W-1:0] SRC_A_RS1    = 2'd2;

    // ALU operand B select
    localparam logic [SEL_W-1:0] SRC_B_RS2  = 2'd0;
    localparam logic [SEL_W-1:0] SRC_B_IMM  = 2'd1;
    localparam logic [SEL_W-1:0] SRC_B_FOUR = 2'd2;

    // Register file write-back select
    localparam logic [SEL_W-1:0] WB_ALUOUT = 2'd0;
    localparam logic [SEL_W-1:0] WB_MDR    = 2'd1;
    localparam logic [SEL_W-1:0] WB_PC     = 2'd2;

endpackage

// File: rtl/unidade_controle_multiciclo_decod_alu.sv
// decod_alu: combinational ALU operation decoder.
// Ports: funct3 (IR[14:12]), funct7_5 (IR[30]), is_imm (1 for OP-IMM),
//        alu_ctrl (ALU operation code).
module decod_alu
    import riscv_pkg::*;
(
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    input  logic             is_imm,
    output logic [ALU_W-1:0] alu_ctrl
);

    // funct7_5 selects SUB only for register ops; for immediates it is
    // part of the immediate except on shift-right, where it picks SRAI.
    always_comb begin
        alu_ctrl = ALU_ADD;
        case (funct3)
            3'b000: alu_ctrl = (funct7_5 && !is_imm) ? ALU_SUB : ALU_ADD;
            3'b001: alu_ctrl = ALU_SLL;
            3'b010: alu_ctrl = ALU_SLT;
            3'b011: alu_ctrl = ALU_SLTU;
            3'b100: alu_ctrl = ALU_XOR;
            3'b101: alu_ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
            3'b110: alu_ctrl = ALU_OR;
            3'b111: alu_ctrl = ALU_AND;
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// unidade_controle_multiciclo: Moore control FSM for a multicycle RV32I
// datapath (fetch, decode, execute, memory, writeback) with a shared
// memory port handshake and a retired-instruction counter.
// Ports: clock/reset (sync, active-high); IR fields opcode/funct3/funct7_5;
//        branch_taken, mem_ready in; memory port controls, datapath enables
//        and mux selects, halted and instret out.
module unidade_controle_multiciclo
    import riscv_pkg::*;
#(
    parameter int unsigned INSTRET_W = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 funct7_5,
    input  logic                 branch_taken,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 mem_addr_sel,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 pc_src,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [3:0]           alu_ctrl,
    output logic                 reg_write,
    output logic [1:0]           wb_sel,
    output logic                 halted,
    output logic [INSTRET_W-1:0] instret
);

    state_t                 state, state_next;
    logic [INSTRET_W-1:0]   instret_q;
    logic                   retire;
    logic                   is_imm;
    logic [ALU_W-1:0]       alu_dec;

    decod_alu u_decod_alu (
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .is_imm   (is_imm),
        .alu_ctrl (alu_dec)
    );

    // State register and retired-instruction counter
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            instret_q <= '0;
        end else begin
            state <= state_next;
            if (retire) begin
                instret_q <= instret_q + INSTRET_W'(1);
            end
        end
    end

    // Next state and outputs; everything is held low while reset is high so
    // the reset cycle itself is quiet regardless of the old state.
    always_comb begin
        state_next   = state;
        retire       = 1'b0;
        is_imm       = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        alu_src_a    = SRC_A_PC;
        alu_src_b    = SRC_B_RS2;
        alu_ctrl     = ALU_ADD;
        reg_write    = 1'b0;
        wb_sel       = WB_ALUOUT;
        halted       = 1'b0;
        instret      = '0;

        if (!reset) begin
            instret = instret_q;
            case (state)
                S_IDLE: state_next = S_FETCH;
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_a = SRC_A_PC;
                    alu_src_b = SRC_B_FOUR;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                    if (mem_ready) state_next = S_DECODE;
                end
                S_DECODE: begin
                    alu_src_a = SRC_A_PC_OLD;
                    alu_src_b = SRC_B_IMM;
                    case (opcode)
                        OP_R:               state_next = S_EXEC_R;
                        OP_I:               state_next = S_EXEC_I;
                        OP_LOAD, OP_STORE:  state_next = S_ADDR;
                        OP_BRANCH:          state_next = S_BRANCH;
                        OP_JAL:             state_next = S_JAL;
                        default:            state_next = S_TRAP;
                    endcase
                end
                S_EXEC_R: begin
                    alu_src_a  = SRC_A_RS1;
                    alu_src_b  = SRC_B_RS2;
                    alu_ctrl   = alu_dec;
                    state_next = S_WB_ALU;
                end
                S_EXEC_I: begin
                    is_imm     = 1'b1;
                    alu_src_a  = SRC_A_RS1;
                    alu_src_b  = SRC_B_IMM;
                    alu_ctrl   = alu_dec;
                    state_next = S_WB_ALU;
                end
                S_ADDR: begin
                    alu_src_a  = SRC_A_RS1;
                    alu_src_b  = SRC_B_IMM;
                    state_next = (opcode == OP_LOAD) ? S_LOAD : S_STORE;
                end
                S_LOAD: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    if (mem_ready) state_next = S_WB_MEM;
                end
                S_STORE: begin
                    mem_req      = 1'b1;
                    mem_we       = 1'b1;
                    mem_addr_sel = 1'b1;
                    if (mem_ready) state_next = S_FETCH;
                end
                S_WB_ALU: begin
                    reg_write  = 1'b1;
                    wb_sel     = WB_ALUOUT;
                    state_next = S_FETCH;
                end
                S_WB_MEM: begin
                    reg_write  = 1'b1;
                    wb_sel     = WB_MDR;
                    state_next = S_FETCH;
                end
                S_BRANCH: begin
                    pc_write   = branch_taken;
                    pc_src     = 1'b1;
                    state_next = S_FETCH;
                end
                S_JAL: begin
                    reg_write  = 1'b1;
                    wb_sel     = WB_PC;
                    pc_write   = 1'b1;
                    pc_src     = 1'b1;
                    state_next = S_FETCH;
                end
                S_TRAP: begin
                    halted = 1'b1;
                end
                default: state_next = S_IDLE;
            endcase

            // An instruction retires when a completing state hands back to fetch
            retire = (state_next == S_FETCH) && (state != S_IDLE) && (state != S_FETCH);
        end
    end

endmodule

// File: doc/unidade_controle_multiciclo.md
# unidade_controle_multiciclo

- Moore FSM that sequences a multicycle RV32I datapath: fetch, decode, execute, memory access and writeback.
- Drives every datapath enable and mux select. Handshakes with a single shared instruction/data memory port (`mem_req`/`mem_ready`).
- Counts retired instructions.
- Sits inside `processador`, between the instruction register fields and the PC, register file, ALU and memory-port muxes.

## Interface
Parameters:
- `INSTRET_W`, default 32: width of the retired-instruction counter.

Ports:
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `opcode`  in  7: IR[6:0].
- `funct3`  in  3: IR[14:12].
- `funct7_5`  in  1: IR[30].
- `branch_taken`  in  1: comparator result for `funct3`, valid in S_BRANCH.
- `mem_ready`  in  1: memory completes the transfer this cycle.
- `mem_req`  out  1: memory access request.
- `mem_we`  out  1: store when high.
- `mem_addr_sel`  out  1: 0 = PC, 1 = ALUOut.
- `ir_write`  out  1: latch IR and pc_old.
- `pc_write`  out  1: load PC from the `pc_src` source.
- `pc_src`  out  1: 0 = ALU result, 1 = ALUOut register.
- `alu_src_a`  out  2: 0 = PC, 1 = pc_old, 2 = rs1.
- `alu_src_b`  out  2: 0 = rs2, 1 = imm, 2 = constant 4.
- `alu_ctrl`  out  4: ALU operation.
- `reg_write`  out  1: register file write.
- `wb_sel`  out  2: 0 = ALUOut, 1 = MDR, 2 = PC (link).
- `halted`  out  1: trap state reached.
- `instret`  out  INSTRET_W: retired-instruction count.

## Operation
**States** (4-bit encoding): S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ADDR, S_LOAD, S_STORE, S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL, S_TRAP.

**State behaviour**
- S_IDLE: all outputs 0 → S_FETCH.
- S_FETCH:
  - Drives `mem_req`=1, `mem_addr_sel`=0, A=PC, B=4, ADD.
  - Holds until `mem_ready`. On `mem_ready`: `ir_write`=1, `pc_write`=1 (`pc_src`=0), → S_DECODE.
- S_DECODE: A=pc_old, B=imm, ADD (branch/jal target into ALUOut). Next state by opcode:
  - 0110011 → S_EXEC_R
  - 0010011 → S_EXEC_I
  - 0000011, 0100011 → S_ADDR
  - 1100011 → S_BRANCH
  - 1101111 → S_JAL
  - anything else → S_TRAP
- S_EXEC_R: A=rs1, B=rs2, op from `funct3`/`funct7_5` → S_WB_ALU.
- S_EXEC_I: A=rs1, B=imm, op from `funct3`. `funct7_5` honoured only for `funct3`=101 (SRAI); ADDI is never SUB. → S_WB_ALU.
- S_ADDR: A=rs1, B=imm, ADD. Load → S_LOAD, store → S_STORE.
- S_LOAD: `mem_req`=1, `mem_addr_sel`=1. Holds until `mem_ready`, then → S_WB_MEM.
- S_STORE: `mem_req`=1, `mem_we`=1, `mem_addr_sel`=1. Holds until `mem_ready`, then → S_FETCH.
- S_WB_ALU: `reg_write`=1, `wb_sel`=0 → S_FETCH.
- S_WB_MEM: `reg_write`=1, `wb_sel`=1 → S_FETCH.
- S_BRANCH: `pc_write`=`branch_taken`, `pc_src`=1 → S_FETCH.
- S_JAL: `reg_write`=1, `wb_sel`=2, `pc_write`=1, `pc_src`=1 → S_FETCH.
- S_TRAP: `halted`=1, all other outputs 0. Absorbing until `reset`.

**Rules**
- Outputs not listed for a state are 0.
- `alu_ctrl` encodings: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLTU 6, SLL 7, SRL 8, SRA 9.
- `instret` increments by 1 on each transition into S_FETCH from a completing state. Transitions from S_IDLE do not count. Wraps modulo 2^INSTRET_W.

## Timing
- Reset values: state = S_IDLE, `instret` = 0, every output 0 during the reset cycle and the cycle after.
- Reset mid-operation (including mid memory wait) drops `mem_req` on the next edge. No completion is counted.
- Cycles per instruction with zero-wait memory:
  - R/I-ALU: 4
  - load: 5
  - store: 4
  - branch: 3
  - jal: 3
- Each wait cycle on `mem_ready` adds one cycle.
- `mem_ready` is ignored when `mem_req` = 0.
- `mem_req` and its qualifiers (`mem_we`, `mem_addr_sel`) stay stable until the `mem_ready` cycle.
- All outputs are decoded from the state register only (pure Moore), except:
  - `ir_write` and `pc_write` in S_FETCH are gated by `mem_ready`.
  - `pc_write` in S_BRANCH follows `branch_taken`.

## Structure
- Package `riscv_pkg`: state enum, opcode constants, `alu_ctrl` encodings, mux-select constants.
- Sub-module `decod_alu`: combinational `funct3`/`funct7_5`/is_imm → `alu_ctrl`. Everything else stays in a single module.

## Test plan
- Reset, then ADD x10,x11,x12 with `mem_ready` tied high → states IDLE, FETCH, DECODE, EXEC_R, WB_ALU. `reg_write`=1 exactly in cycle 5; `instret`=1 after.
- LW with `mem_ready` delayed 3 cycles in both FETCH and LOAD → `mem_req` held 4 cycles in each. Total 11 cycles; `wb_sel`=1 in WB_MEM.
- BEQ with `branch_taken`=0, then =1 → `pc_write` 0 vs 1 in S_BRANCH with `pc_src`=1; 3 cycles each.
- SRAI (`funct3`=101, `funct7_5`=1) → `alu_ctrl`=9. ADDI with `funct7_5`=1 → `alu_ctrl`=0.
- Opcode 0000000 → S_TRAP, `halted`=1 held for 20 cycles with `mem_req`=0. `reset` returns all outputs to 0 and `instret` to 0.
- Preload `instret` to all-ones via 2^INSTRET_W−1 retirements (INSTRET_W=4, 15 instructions) → next retirement wraps to 0. Also: `reset` asserted in S_LOAD during a wait → `mem_req`=0 next cycle, state S_IDLE.
